// File: rtl/rf_pkg.sv
// Shared types and sizes for the operand-fetch stage and its register file.
package rf_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned NREGS  = 8;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      HOLD   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Register-file write port, fetch request and operand handshake of the operand-fetch stage.
interface operand_fetch_if;
   import rf_pkg::*;

   logic     wr_en;
   reg_idx_t wr_num;
   word_t    wr_data;
   logic     start;
   reg_idx_t rn;
   reg_idx_t rm;
   logic     out_ready;
   logic     busy;
   logic     out_valid;
   word_t    a_out;
   word_t    b_out;

   // Requester / producer side.
   modport master (
      output wr_en, wr_num, wr_data, start, rn, rm, out_ready,
      input  busy, out_valid, a_out, b_out
   );

   // Operand-fetch stage side.
   modport slave (
      input  wr_en, wr_num, wr_data, start, rn, rm, out_ready,
      output busy, out_valid, a_out, b_out
   );

endinterface

// File: rtl/regfile8.sv
// 8 x 16-bit register file: synchronous write port, combinational read port.
module regfile8
   import rf_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     wr_en_i,
   input  reg_idx_t wr_num_i,
   input  word_t    wr_data_i,
   input  reg_idx_t rd_num_i,
   output word_t    rd_data_o
);

   word_t mem_q [NREGS];

   // Storage: cleared on reset, otherwise written when enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_num_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_num_i];

endmodule

// File: rtl/operand_fetch.sv
// Multi-cycle operand fetch: reads Rn then Rm into operand latches, presents the pair
// with a valid/ready handshake. Define OPERAND_FETCH_BYPASS_EN to forward a same-cycle
// register write into the operand being captured.
module operand_fetch
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   operand_fetch_if.slave    bus
);

   fetch_state_t state_q;
   reg_idx_t     rn_q;
   reg_idx_t     rm_q;
   word_t        a_q;
   word_t        b_q;
   logic         busy_q;
   logic         valid_q;

   reg_idx_t     rd_num;
   word_t        rd_data;
   word_t        cap_data;

   // Single read port is shared: Rm in READ_B, Rn otherwise.
   assign rd_num = (state_q == READ_B) ? rm_q : rn_q;

   regfile8 u_rf (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (bus.wr_en),
      .wr_num_i  (bus.wr_num),
      .wr_data_i (bus.wr_data),
      .rd_num_i  (rd_num),
      .rd_data_o (rd_data)
   );

`ifdef OPERAND_FETCH_BYPASS_EN
   // Write-through: a write landing on the index being captured wins.
   assign cap_data = (bus.wr_en && (bus.wr_num == rd_num)) ? bus.wr_data : rd_data;
`else
   assign cap_data = rd_data;
`endif

   // Fetch sequencer with registered busy/valid and operand latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rn_q    <= '0;
         rm_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  rn_q    <= bus.rn;
                  rm_q    <= bus.rm;
                  busy_q  <= 1'b1;
                  state_q <= READ_A;
               end
            end
            READ_A: begin
               a_q     <= cap_data;
               state_q <= READ_B;
            end
            READ_B: begin
               b_q     <= cap_data;
               valid_q <= 1'b1;
               state_q <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (bus.start) begin
                     rn_q    <= bus.rn;
                     rm_q    <= bus.rm;
                     state_q <= READ_A;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = valid_q;
   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;

endmodule
